// File: rtl/ltsm_sb_pkg.sv
// rtl/ltsm_sb_pkg.sv - shared encodings for LTSM sideband TX packetizers
package ltsm_sb_pkg;

    // Encoded message values produced by the LTSM state wrappers
    localparam int MSG_NONE   = 0;
    localparam int START_REQ  = 1;
    localparam int START_RESP = 2;
    localparam int END_REQ    = 3;
    localparam int END_RESP   = 4;

    // Sideband MsgCode / MsgSubcode values for the PHYRETRAIN messages
    localparam logic [7:0] MSGCODE_REQ   = 8'hB5;
    localparam logic [7:0] MSGCODE_RESP  = 8'hBA;
    localparam logic [7:0] SUBCODE_START = 8'h01;
    localparam logic [7:0] SUBCODE_END   = 8'h02;

    // Packetizer FSM state encoding
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WAIT_FREE = 3'd1;
    localparam logic [2:0] ST_ISSUE     = 3'd2;
    localparam logic [2:0] ST_WAIT_ACK  = 3'd3;
    localparam logic [2:0] ST_WAIT_DONE = 3'd4;

    // Captured sideband header fields for one request
    typedef struct packed {
        logic [7:0] msgcode;
        logic [7:0] msgsubcode;
    } sb_code_t;

endpackage

// File: rtl/ltsm_sb_code_lut.sv
// rtl/ltsm_sb_code_lut.sv - encoded LTSM message to MsgCode/MsgSubcode lookup
module ltsm_sb_code_lut
    import ltsm_sb_pkg::*;
#(
    parameter int SB_MSG_WIDTH = 4
) (
    input  logic [SB_MSG_WIDTH-1:0] code,
    output logic [7:0]              msgcode,
    output logic [7:0]              msgsubcode,
    output logic                    legal
);

    // Pure decode; code 0 (none) and any unmapped value report not-legal
    always_comb begin
        msgcode    = 8'h00;
        msgsubcode = 8'h00;
        legal      = 1'b0;
        case (code)
            SB_MSG_WIDTH'(START_REQ): begin
                msgcode    = MSGCODE_REQ;
                msgsubcode = SUBCODE_START;
                legal      = 1'b1;
            end
            SB_MSG_WIDTH'(START_RESP): begin
                msgcode    = MSGCODE_RESP;
                msgsubcode = SUBCODE_START;
                legal      = 1'b1;
            end
            SB_MSG_WIDTH'(END_REQ): begin
                msgcode    = MSGCODE_REQ;
                msgsubcode = SUBCODE_END;
                legal      = 1'b1;
            end
            SB_MSG_WIDTH'(END_RESP): begin
                msgcode    = MSGCODE_RESP;
                msgsubcode = SUBCODE_END;
                legal      = 1'b1;
            end
            default: begin
                msgcode    = 8'h00;
                msgsubcode = 8'h00;
                legal      = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ltsm_sb_tx_packetizer.sv
// rtl/ltsm_sb_tx_packetizer.sv - level LTSM request to one-shot sideband packet
module ltsm_sb_tx_packetizer
    import ltsm_sb_pkg::*;
#(
    parameter int SB_MSG_WIDTH = 4,
    parameter int TIMEOUT_CYC  = 1024
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_state_en,
    input  logic                    i_tx_msg_valid,
    input  logic [SB_MSG_WIDTH-1:0] i_encoded_SB_msg,
    input  logic [2:0]              i_tx_msg_info,
    input  logic                    i_SB_Busy,
    output logic                    o_pkt_valid,
    output logic [7:0]              o_msgcode,
    output logic [7:0]              o_msgsubcode,
    output logic [15:0]             o_msginfo,
    output logic                    o_sent,
    output logic                    o_pending,
    output logic                    o_err
);

    localparam int              CNT_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

    logic [2:0]              state;
    logic [2:0]              state_d;
    logic                    busy_q;
    logic [CNT_W-1:0]        cnt;
    logic [SB_MSG_WIDTH-1:0] hold_code;
    logic [2:0]              hold_info;
    sb_code_t                hold_hdr;
    logic [SB_MSG_WIDTH-1:0] last_code;
    logic [2:0]              last_info;
    logic                    low_seen;

    logic [7:0]              lut_msgcode;
    logic [7:0]              lut_msgsubcode;
    logic                    lut_legal;

    logic                    is_new;
    logic                    capture;
    logic                    issue;
    logic                    clr_cnt;
    logic                    inc_cnt;
    logic                    set_err;
    logic                    sent_d;

    ltsm_sb_code_lut #(
        .SB_MSG_WIDTH (SB_MSG_WIDTH)
    ) u_code_lut (
        .code       (i_encoded_SB_msg),
        .msgcode    (lut_msgcode),
        .msgsubcode (lut_msgsubcode),
        .legal      (lut_legal)
    );

    // A held request counts once: it must differ from the last sent pair or follow a valid-low gap
    assign is_new = ({i_encoded_SB_msg, i_tx_msg_info} != {last_code, last_info}) || low_seen;

    // Next-state and per-cycle action decode
    always_comb begin
        state_d = state;
        capture = 1'b0;
        issue   = 1'b0;
        clr_cnt = 1'b0;
        inc_cnt = 1'b0;
        set_err = 1'b0;
        sent_d  = 1'b0;
        if (!i_state_en) begin
            state_d = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_tx_msg_valid && (i_encoded_SB_msg != '0)) begin
                        if (!lut_legal) begin
                            set_err = 1'b1;
                        end else if (is_new) begin
                            capture = 1'b1;
                            state_d = ST_WAIT_FREE;
                        end
                    end
                end
                ST_WAIT_FREE: begin
                    if (!i_SB_Busy) begin
                        issue   = 1'b1;
                        state_d = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    clr_cnt = 1'b1;
                    state_d = ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (i_SB_Busy) begin
                        state_d = ST_WAIT_DONE;
                    end else if (cnt == CNT_MAX) begin
                        set_err = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        inc_cnt = 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (busy_q && !i_SB_Busy) begin
                        sent_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM state, busy history and registered handshake outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= ST_IDLE;
            busy_q       <= 1'b0;
            o_pkt_valid  <= 1'b0;
            o_sent       <= 1'b0;
            o_pending    <= 1'b0;
            o_msgcode    <= 8'h00;
            o_msgsubcode <= 8'h00;
            o_msginfo    <= 16'h0000;
        end else begin
            state       <= state_d;
            busy_q      <= i_SB_Busy;
            o_pkt_valid <= issue;
            o_sent      <= sent_d;
            o_pending   <= (state_d != ST_IDLE);
            if (issue) begin
                o_msgcode    <= hold_hdr.msgcode;
                o_msgsubcode <= hold_hdr.msgsubcode;
                o_msginfo    <= {13'b0, hold_info};
            end
        end
    end

    // Request holding, last-sent history, timeout counter and sticky error
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hold_code <= '0;
            hold_info <= '0;
            hold_hdr  <= '0;
            last_code <= '0;
            last_info <= '0;
            low_seen  <= 1'b0;
            cnt       <= '0;
            o_err     <= 1'b0;
        end else if (!i_state_en) begin
            hold_code <= '0;
            hold_info <= '0;
            hold_hdr  <= '0;
            last_code <= '0;
            last_info <= '0;
            low_seen  <= 1'b0;
            cnt       <= '0;
            o_err     <= 1'b0;
        end else begin
            if (capture) begin
                hold_code           <= i_encoded_SB_msg;
                hold_info           <= i_tx_msg_info;
                hold_hdr.msgcode    <= lut_msgcode;
                hold_hdr.msgsubcode <= lut_msgsubcode;
            end
            if (clr_cnt) begin
                cnt <= '0;
            end else if (inc_cnt && (cnt != CNT_MAX)) begin
                cnt <= cnt + 1'b1;
            end
            if (set_err) begin
                o_err <= 1'b1;
            end
            if (sent_d) begin
                last_code <= hold_code;
                last_info <= hold_info;
                low_seen  <= 1'b0;
            end else if (!i_tx_msg_valid) begin
                low_seen  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ltsm_sb_tx_packetizer.sv
// tb/tb_ltsm_sb_tx_packetizer.sv - self-checking bench for ltsm_sb_tx_packetizer
module tb_ltsm_sb_tx_packetizer;

    localparam int W = 4;
    localparam int T = 16;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        state_en = 1'b0;
    logic        valid    = 1'b0;
    logic        busy     = 1'b0;
    logic [W-1:0] code    = '0;
    logic [2:0]  info     = '0;

    logic        o_pkt_valid;
    logic [7:0]  o_msgcode;
    logic [7:0]  o_msgsubcode;
    logic [15:0] o_msginfo;
    logic        o_sent;
    logic        o_pending;
    logic        o_err;

    int checks   = 0;
    int errors   = 0;
    int pkt_cnt  = 0;
    int sent_cnt = 0;
    logic [31:0] sb[$];

    ltsm_sb_tx_packetizer #(
        .SB_MSG_WIDTH (W),
        .TIMEOUT_CYC  (T)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_state_en       (state_en),
        .i_tx_msg_valid   (valid),
        .i_encoded_SB_msg (code),
        .i_tx_msg_info    (info),
        .i_SB_Busy        (busy),
        .o_pkt_valid      (o_pkt_valid),
        .o_msgcode        (o_msgcode),
        .o_msgsubcode     (o_msgsubcode),
        .o_msginfo        (o_msginfo),
        .o_sent           (o_sent),
        .o_pending        (o_pending),
        .o_err            (o_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard: every packet strobe must match the oldest expected packet
    always @(negedge clk) begin
        if (o_sent) sent_cnt++;
        if (o_pkt_valid) begin
            pkt_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_pkt: observed %h expected none", {o_msgcode, o_msgsubcode, o_msginfo});
            end else begin
                chk("pkt_fields", {o_msgcode, o_msgsubcode, o_msginfo}, sb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] c, input logic [7:0] s, input logic [2:0] i);
        sb.push_back({c, s, 13'b0, i});
    endtask

    task automatic wait_sent();
        bit seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            step();
            if (o_sent) begin
                seen = 1'b1;
                chk("pending_clear_at_sent", o_pending, 1'b0);
            end
        end
        chk("sent_seen", seen, 1'b1);
    endtask

    task automatic ack();
        busy = 1'b1;
        step();
        step();
        busy = 1'b0;
        wait_sent();
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {o_pkt_valid, o_sent, o_pending, o_err, o_msgcode, o_msgsubcode, o_msginfo}, 36'h0);
    endtask

    initial begin
        int c0;
        bit bad;

        // Reset state
        step();
        step();
        chk_all_zero("reset_outputs");
        rst_n    = 1'b1;
        state_en = 1'b1;

        // Held request, busy low: one packet at N+2, one o_sent after busy pulse
        push(8'hB5, 8'h01, 3'd3);
        valid = 1'b1; code = 4'd1; info = 3'd3;
        step();
        chk("t1_pending_n1", o_pending, 1'b1);
        chk("t1_no_pkt_n1", o_pkt_valid, 1'b0);
        step();
        chk("t1_pkt_n2", o_pkt_valid, 1'b1);
        chk("t1_fields", {o_msgcode, o_msgsubcode, o_msginfo}, 32'hB501_0003);
        busy = 1'b1;
        repeat (4) step();
        busy = 1'b0;
        wait_sent();
        repeat (12) step();
        chk("t1_one_pkt", pkt_cnt, 1);
        chk("t1_one_sent", sent_cnt, 1);

        // Busy high at request; pkt the cycle after busy is first sampled low
        valid = 1'b0;
        step();
        push(8'hB5, 8'h02, 3'd5);
        busy = 1'b1; valid = 1'b1; code = 4'd3; info = 3'd5;
        bad = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (o_pkt_valid || !o_pending) bad = 1'b1;
        end
        chk("t2_wait_while_busy", bad, 1'b0);
        busy = 1'b0;
        step();
        chk("t2_pkt_after_free", o_pkt_valid, 1'b1);
        chk("t2_pending_in_issue", o_pending, 1'b1);
        ack();

        // Same pair re-sent only after a valid-low gap
        valid = 1'b0;
        step();
        push(8'hBA, 8'h01, 3'd0);
        valid = 1'b1; code = 4'd2; info = 3'd0;
        step();
        step();
        chk("t3_first_pkt", o_pkt_valid, 1'b1);
        ack();
        valid = 1'b0;
        step();
        valid = 1'b1;
        push(8'hBA, 8'h01, 3'd0);
        step();
        step();
        chk("t3_resend_pkt", o_pkt_valid, 1'b1);
        ack();
        c0 = pkt_cnt;
        repeat (10) step();
        chk("t3_no_repeat", pkt_cnt, c0);

        // Illegal code sets sticky error, nothing sent; state_en low clears it
        code = 4'd7;
        step();
        chk("t4_err_set", o_err, 1'b1);
        repeat (3) step();
        chk("t4_not_pending", o_pending, 1'b0);
        chk("t4_no_pkt", pkt_cnt, c0);
        valid = 1'b0; state_en = 1'b0;
        step();
        chk("t4_err_cleared", o_err, 1'b0);
        state_en = 1'b1;

        // Busy never rises: timeout error, back to IDLE, then the held request re-sends
        push(8'hBA, 8'h02, 3'd1);
        valid = 1'b1; code = 4'd4; info = 3'd1;
        step();
        step();
        chk("t5_pkt", o_pkt_valid, 1'b1);
        repeat (T - 1) step();
        chk("t5_no_err_yet", o_err, 1'b0);
        push(8'hBA, 8'h02, 3'd1);
        step();
        step();
        chk("t5_timeout_err", o_err, 1'b1);
        chk("t5_idle_after_timeout", o_pending, 1'b0);
        step();
        chk("t5_recaptured", o_pending, 1'b1);
        step();
        chk("t5_resend_pkt", o_pkt_valid, 1'b1);
        ack();

        // Asynchronous reset while in WAIT_DONE, then a fresh packet for the held request
        valid = 1'b0;
        step();
        push(8'hB5, 8'h01, 3'd6);
        valid = 1'b1; code = 4'd1; info = 3'd6;
        step();
        step();
        chk("t6_pkt", o_pkt_valid, 1'b1);
        busy = 1'b1;
        step();
        step();
        chk("t6_pending_wait_done", o_pending, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("t6_async_reset");
        busy = 1'b0;
        step();
        rst_n = 1'b1;
        push(8'hB5, 8'h01, 3'd6);
        step();
        step();
        chk("t6_fresh_pkt", o_pkt_valid, 1'b1);
        ack();

        repeat (3) step();
        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ltsm_sb_tx_packetizer.md
# ltsm_sb_tx_packetizer

Converts the level-style `{valid, 4-bit encoded message, 3-bit info}` request produced by LTSM training-state wrappers (PHYRETRAIN and siblings) into single-cycle sideband message packets: MsgCode, MsgSubcode and MsgInfo. It sits directly downstream of the state wrapper and upstream of the sideband TX path. It de-duplicates held requests, waits for the sideband to be free, tracks the sideband busy handshake, and flags stuck or illegal requests.

## Interface
- `SB_MSG_WIDTH`, default 4: encoded message width.
- `TIMEOUT_CYC`, default 1024: maximum cycles to wait for `i_SB_Busy` to rise after a packet is issued.
- `i_clk` input, 1: clock.
- `i_rst_n` input, 1: reset, asynchronous, active-low.
- `i_state_en` input, 1: the owning LTSM state is active. Low forces IDLE and clears history.
- `i_tx_msg_valid` input, 1: upstream request, level.
- `i_encoded_SB_msg` input, SB_MSG_WIDTH: encoded message; 0 means none.
- `i_tx_msg_info` input, 3: retrain-encoding info, placed in MsgInfo[2:0].
- `i_SB_Busy` input, 1: sideband TX busy.
- `o_pkt_valid` output, 1: one-cycle packet strobe to sideband.
- `o_msgcode` output, 8: MsgCode.
- `o_msgsubcode` output, 8: MsgSubcode.
- `o_msginfo` output, 16: `{13'b0, info}`.
- `o_sent` output, 1: one-cycle pulse when sideband busy falls after the packet.
- `o_pending` output, 1: a request is captured and not yet sent.
- `o_err` output, 1: sticky error for an illegal encoding or a timeout. Cleared when `i_state_en` is low.

## Operation
- Encoding map (code → MsgCode/MsgSubcode):
  - 1 → 0xB5/0x01 (PHYRETRAIN.retrain.start.req)
  - 2 → 0xBA/0x01 (start.resp)
  - 3 → 0xB5/0x02 (retrain.end.req)
  - 4 → 0xBA/0x02 (end.resp)
  - 5–15 illegal.
- FSM states: IDLE, WAIT_FREE, ISSUE, WAIT_ACK, WAIT_DONE.
- IDLE → WAIT_FREE when all of the following hold:
  - `i_state_en`, `i_tx_msg_valid` and a nonzero legal code are present;
  - the request is new, meaning `{code, info}` differs from the last sent pair, or valid was low at least one cycle since the last send.
- On that transition, capture code and info into holding registers. Later input changes are ignored until `o_sent`.
- Illegal code with valid high: set `o_err`, stay in IDLE, send nothing.
- WAIT_FREE → ISSUE when `i_SB_Busy` is 0.
- ISSUE: lasts one cycle. `o_pkt_valid` is 1 and the code fields are driven from the holding registers. Next state is WAIT_ACK, and the timeout counter is cleared.
- WAIT_ACK:
  - `i_SB_Busy`=1 → WAIT_DONE.
  - Counter reaches TIMEOUT_CYC-1 → set `o_err`, go to IDLE, drop the request. The last-sent pair is not updated.
- WAIT_DONE:
  - Falling edge of `i_SB_Busy` (registered previous value 1, current 0) → pulse `o_sent`.
  - On the same edge, record the last-sent pair, clear the valid-low flag, go to IDLE.
- `o_pending` = state ∉ {IDLE}.
- The code fields hold their last value outside ISSUE. The sideband qualifies them only with `o_pkt_valid`.
- `i_state_en` low in any state: on the next edge go to IDLE and clear the holding, last-sent, counter and `o_err` registers. No `o_sent` is produced.

## Timing
- Reset values: state IDLE; `o_pkt_valid`, `o_sent`, `o_pending`, `o_err` all 0; `o_msgcode`, `o_msgsubcode`, `o_msginfo` all 0; previous-busy register 0.
- All outputs are registered.
- Latency with busy low: new request at cycle N (sampled) → WAIT_FREE at N+1 → `o_pkt_valid` at N+2.
- Busy high at request: `o_pkt_valid` occurs the cycle after the first cycle with busy sampled 0.
- Busy rising in the same cycle as ISSUE counts as acknowledgment in the following WAIT_ACK cycle.
- Busy toggling 1→0 while in WAIT_ACK does not produce `o_sent`; only a rise followed by a fall does.
- A held valid with the same pair produces exactly one packet.
- Same pair re-sent requires valid low for one or more cycles.
- Timeout counter is 10 bits for the default. Width is `$clog2(TIMEOUT_CYC)`, saturating; no wrap.

## Structure
- Shared package `ltsm_sb_pkg`: encoded-message localparams (MSG_NONE, START_REQ, START_RESP, END_REQ, END_RESP), the MsgCode/MsgSubcode constants, and the FSM state encoding.
- One combinational sub-module, `ltsm_sb_code_lut`: maps code to `{msgcode, msgsubcode, legal}`. It is reusable by the other stage packetizers.

## Test plan
- Busy 0; valid=1, code=1, info=3 held 20 cycles → exactly one `o_pkt_valid` at N+2 with 0xB5/0x01/0x0003. Busy driven 1 for 4 cycles then 0 → one `o_sent`.
- Busy 1 at request, falling at cycle 10 → `o_pkt_valid` at cycle 11; `o_pending`=1 from N+1 until `o_sent`.
- Code=2, sent, valid dropped one cycle, code=2 again → second packet 0xBA/0x01. Without the drop → no second packet.
- Code=7 with valid → `o_err`=1, no packet. `i_state_en` low one cycle → `o_err`=0.
- Busy never rises after ISSUE → `o_err` at ISSUE+TIMEOUT_CYC, state IDLE. Same request then re-sends.
- `i_rst_n` asserted in WAIT_DONE → all outputs 0 immediately. After release, the held valid produces a fresh packet.
